// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM front-end arbiter.
// Arbiter FSM states, owner tracking and bus width constants.
package sdram_arb_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    VID,
    VID_DATA
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_VID
  } owner_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running divider: one-cycle pulse every REFRESH_DIV clocks (legal 2..65535).
// Latency: pulse is decoded from the counter register; no backpressure, the controller defers refresh.
module sdram_refresh_timer #(
  parameter int REFRESH_DIV = 700
) (
  input  logic clk,
  input  logic reset,
  output logic pulse
);

  localparam logic [15:0] LAST = 16'(REFRESH_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  assign pulse = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (pulse) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// CPU/video arbiter in front of the SDRAM controller, plus refresh strobe; level oe/we/dtack handshake.
// Optional CPU stall counter on stat_cpu_wait when SDRAM_ARB_STATS_EN is defined.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int REFRESH_DIV    = 700,
  parameter int VID_DATA_DELAY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              cpu_uds,
  input  logic              cpu_lds,
  input  logic              cpu_oe,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_dtack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_uds,
  output logic              ram_lds,
  output logic              ram_oe,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_dtack,
  output logic              ram_refresh,
  output logic [15:0]       stat_cpu_wait
);

  localparam logic [7:0] DLY_LAST = 8'(VID_DATA_DELAY - 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_ack_q, vid_ack_d;
  logic [7:0]        dly_q, dly_d;
  logic              cpu_req;

  assign cpu_req  = cpu_oe | cpu_we;
  assign cpu_dout = ram_dout;
  assign vid_data = vid_data_q;
  assign vid_ack  = vid_ack_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    vid_addr_d = vid_addr_q;
    vid_data_d = vid_data_q;
    vid_ack_d  = 1'b0;
    dly_d      = dly_q;
    ram_addr   = '0;
    ram_din    = '0;
    ram_uds    = 1'b0;
    ram_lds    = 1'b0;
    ram_oe     = 1'b0;
    ram_we     = 1'b0;
    cpu_dtack  = 1'b0;
    case (state_q)
      IDLE: begin
        // A high dtack here means the controller has not released the previous cycle yet.
        if (!ram_dtack) begin
          if (vid_req && !(cpu_req && owner_q == OWN_VID)) begin
            state_d    = VID;
            vid_addr_d = vid_addr;
          end else if (cpu_req) begin
            state_d = CPU;
          end
        end
      end
      CPU: begin
        ram_addr  = cpu_addr;
        ram_din   = cpu_din;
        ram_uds   = cpu_uds;
        ram_lds   = cpu_lds;
        ram_oe    = cpu_oe;
        ram_we    = cpu_we;
        cpu_dtack = ram_dtack;
        if (!cpu_req) begin
          state_d = IDLE;
          owner_d = OWN_CPU;
        end
      end
      VID: begin
        ram_addr = vid_addr_q;
        ram_uds  = 1'b1;
        ram_lds  = 1'b1;
        ram_oe   = 1'b1;
        if (ram_dtack) begin
          state_d = VID_DATA;
          dly_d   = '0;
        end
      end
      VID_DATA: begin
        if (dly_q == DLY_LAST) begin
          vid_data_d = ram_dout;
          vid_ack_d  = 1'b1;
          state_d    = IDLE;
          owner_d    = OWN_VID;
        end else begin
          dly_d = dly_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      vid_addr_q <= '0;
      vid_data_q <= '0;
      vid_ack_q  <= 1'b0;
      dly_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      vid_addr_q <= vid_addr_d;
      vid_data_q <= vid_data_d;
      vid_ack_q  <= vid_ack_d;
      dly_q      <= dly_d;
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (cpu_req && state_q != CPU && stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_cpu_wait = stat_q;
`else
  assign stat_cpu_wait = '0;
`endif

  sdram_refresh_timer #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_refresh (
    .clk  (clk),
    .reset(reset),
    .pulse(ram_refresh)
  );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: CPU read/write, video fetch, contention, refresh, reset mid-fetch.
// Builds with or without SDRAM_ARB_STATS_EN; stall-count expectations follow the macro.
module tb_sdram_arbiter;

`ifdef SDRAM_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif
  localparam logic [23:0] VID_A = 24'h030000;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] cpu_addr, vid_addr, ram_addr;
  logic [15:0] cpu_din, cpu_dout, vid_data, ram_din, ram_dout, stat_cpu_wait;
  logic        cpu_uds, cpu_lds, cpu_oe, cpu_we, cpu_dtack;
  logic        vid_req, vid_ack;
  logic        ram_uds, ram_lds, ram_oe, ram_we, ram_dtack, ram_refresh;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int last_ref = -1;
  int n_ref = 0;
  bit mon_en = 1'b0;
  int ack_base;
  int who;
  int n;
  int exp_who [4] = '{0, 1, 0, 1};

  sdram_arbiter #(
    .REFRESH_DIV(8),
    .VID_DATA_DELAY(2)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_uds(cpu_uds), .cpu_lds(cpu_lds),
    .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_dout(cpu_dout), .cpu_dtack(cpu_dtack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_uds(ram_uds), .ram_lds(ram_lds),
    .ram_oe(ram_oe), .ram_we(ram_we), .ram_dout(ram_dout), .ram_dtack(ram_dtack),
    .ram_refresh(ram_refresh), .stat_cpu_wait(stat_cpu_wait)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (vid_ack) ack_cnt++;
    if (mon_en && ram_refresh) begin
      if (last_ref >= 0) chk("refresh_period", 32'(cyc - last_ref), 32'd8);
      last_ref = cyc;
      n_ref++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpu_addr = '0; cpu_din = '0; cpu_uds = 1'b0; cpu_lds = 1'b0;
    cpu_oe = 1'b0; cpu_we = 1'b0; vid_req = 1'b0; vid_addr = '0;
    ram_dout = '0; ram_dtack = 1'b0;
    tick(); tick();
    chk("rst_ram_oe", 32'(ram_oe), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_cpu_dtack", 32'(cpu_dtack), 0);
    chk("rst_vid_ack", 32'(vid_ack), 0);
    chk("rst_vid_data", 32'(vid_data), 0);
    chk("rst_refresh", 32'(ram_refresh), 0);
    chk("rst_stat", 32'(stat_cpu_wait), 0);
    reset = 1'b0;

    // CPU read alone
    cpu_addr = 24'h000123; cpu_oe = 1'b1;
    tick();
    chk("rd_ram_oe", 32'(ram_oe), 1);
    chk("rd_ram_addr", 32'(ram_addr), 32'h000123);
    chk("rd_dtack_lo", 32'(cpu_dtack), 0);
    ram_dtack = 1'b1; ram_dout = 16'h5A5A; #1;
    chk("rd_dtack_hi", 32'(cpu_dtack), 1);
    chk("rd_dout", 32'(cpu_dout), 32'h5A5A);
    tick();
    cpu_oe = 1'b0; #1;
    chk("rd_oe_drop", 32'(ram_oe), 0);
    tick();
    chk("rd_dtack_exit", 32'(cpu_dtack), 0);
    ram_dtack = 1'b0;
    tick();

    // Video fetch
    ack_base = ack_cnt;
    vid_addr = 24'h020000; vid_req = 1'b1;
    tick();
    chk("vf_ram_oe", 32'(ram_oe), 1);
    chk("vf_ram_addr", 32'(ram_addr), 32'h020000);
    chk("vf_strobes", 32'({ram_uds, ram_lds, ram_we}), 32'b110);
    vid_addr = 24'h777777; vid_req = 1'b0; #1;
    chk("vf_addr_latched", 32'(ram_addr), 32'h020000);
    tick();
    ram_dtack = 1'b1;
    tick();
    chk("vf_oe_dropped", 32'(ram_oe), 0);
    ram_dtack = 1'b0; ram_dout = 16'h1111;
    tick();
    chk("vf_ack_early", 32'(vid_ack), 0);
    ram_dout = 16'hBEEF;
    tick();
    chk("vf_ack", 32'(vid_ack), 1);
    chk("vf_data", 32'(vid_data), 32'hBEEF);
    ram_dout = 16'h0000;
    tick();
    chk("vf_ack_pulse", 32'(vid_ack), 0);
    chk("vf_data_hold", 32'(vid_data), 32'hBEEF);
    chk("vf_ack_count", 32'(ack_cnt - ack_base), 1);

    // Contention: last owner was video, so CPU goes first
    mon_en = 1'b1; last_ref = -1; n_ref = 0;
    cpu_addr = 24'h000456; cpu_oe = 1'b1; vid_addr = VID_A; vid_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(ram_oe || ram_we) && n < 10) begin tick(); n++; end
      chk("ct_grant_seen", 32'(ram_oe), 1);
      who = (ram_addr == VID_A) ? 1 : 0;
      chk($sformatf("ct_grant%0d", i), 32'(who), 32'(exp_who[i]));
      if (who == 0) begin
        ram_dtack = 1'b1; #1;
        chk("ct_cpu_dtack", 32'(cpu_dtack), 1);
        tick();
        cpu_oe = 1'b0;
        tick();
        cpu_oe = 1'b1; #1;
        chk("ct_holdoff_a", 32'(ram_oe), 0);
        tick();
        chk("ct_holdoff_b", 32'(ram_oe), 0);
        ram_dtack = 1'b0;
        tick();
      end else begin
        ram_dtack = 1'b1;
        tick();
        ram_dtack = 1'b0; ram_dout = 16'(16'h3000 + i);
        n = 0;
        while (!vid_ack && n < 8) begin tick(); n++; end
        chk("ct_vid_ack", 32'(vid_ack), 1);
        chk("ct_vid_data", 32'(vid_data), 32'(16'h3000 + i));
      end
    end
    cpu_oe = 1'b0; vid_req = 1'b0;
    tick();

    // CPU byte write with early dtack
    cpu_addr = 24'h000789; cpu_din = 16'h12AB; cpu_uds = 1'b1; cpu_lds = 1'b0; cpu_we = 1'b1;
    tick();
    chk("wr_ram_we", 32'(ram_we), 1);
    chk("wr_ram_oe", 32'(ram_oe), 0);
    chk("wr_strobes", 32'({ram_uds, ram_lds}), 32'b10);
    chk("wr_din", 32'(ram_din), 32'h12AB);
    chk("wr_addr", 32'(ram_addr), 32'h000789);
    ram_dtack = 1'b1; #1;
    chk("wr_dtack", 32'(cpu_dtack), 1);
    tick(); tick();
    chk("wr_held_we", 32'(ram_we), 1);
    chk("wr_held_din", 32'(ram_din), 32'h12AB);
    chk("wr_held_lds", 32'(ram_lds), 0);
    cpu_we = 1'b0;
    tick();
    chk("wr_released", 32'({ram_we, cpu_dtack}), 0);
    ram_dtack = 1'b0;
    tick();
    mon_en = 1'b0;
    chk("refresh_seen", 32'(n_ref >= 2), 1);

    // Reset while video owns the bus and dtack is high
    vid_addr = 24'h040000; vid_req = 1'b1;
    tick();
    chk("rv_granted", 32'(ram_oe), 1);
    ack_base = ack_cnt;
    ram_dtack = 1'b1; vid_req = 1'b0; cpu_addr = 24'h000999; cpu_oe = 1'b1; reset = 1'b1;
    tick();
    chk("rv_oe_low", 32'(ram_oe), 0);
    chk("rv_cpu_dtack", 32'(cpu_dtack), 0);
    chk("rv_stat_clr", 32'(stat_cpu_wait), 0);
    reset = 1'b0;
    tick(); tick();
    chk("rv_no_grant", 32'(ram_oe), 0);
    chk("rv_cpu_dtack2", 32'(cpu_dtack), 0);
    chk("rv_stat_wait", 32'(stat_cpu_wait), STATS_ON ? 32'd2 : 32'd0);
    ram_dtack = 1'b0;
    tick();
    chk("rv_cpu_grant", 32'(ram_oe), 1);
    chk("rv_cpu_addr", 32'(ram_addr), 32'h000999);
    chk("rv_stat_grant", 32'(stat_cpu_wait), STATS_ON ? 32'd3 : 32'd0);
    tick();
    chk("rv_stat_held", 32'(stat_cpu_wait), STATS_ON ? 32'd3 : 32'd0);
    chk("rv_no_ack", 32'(ack_cnt - ack_base), 0);
    cpu_oe = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
